// File: rtl/sun_video_fb.sv
// Monochrome framebuffer: 16-bit bus port into a dual-port VRAM, control/status register,
// and a raster scanner shifting one pixel per clock with a fixed two-clock output latency.
module sun_video_fb #(
  parameter int unsigned H_ACTIVE = 1152,
  parameter int unsigned H_TOTAL  = 1504,
  parameter int unsigned HS_START = 1192,
  parameter int unsigned HS_END   = 1304,
  parameter int unsigned V_ACTIVE = 900,
  parameter int unsigned V_TOTAL  = 937,
  parameter int unsigned VS_START = 901,
  parameter int unsigned VS_END   = 905,
  parameter int unsigned AW       = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [22:0] i_addr,
  input  logic        i_decode,
  input  logic        i_decode_ctl,
  input  logic        i_wel_n,
  input  logic        i_weu_n,
  input  logic        i_go_n,
  output logic        o_wait_n,
  input  logic [15:0] i_datai,
  output logic [15:0] o_datao,
  output logic        o_pixel,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic        o_blank,
  output logic        o_irq
);

  localparam int unsigned HW = $clog2(H_TOTAL + 1);
  localparam int unsigned VW = $clog2(V_TOTAL + 1);
  localparam logic [HW-1:0] HLast = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] HAct  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HsS   = HW'(HS_START);
  localparam logic [HW-1:0] HsE   = HW'(HS_END);
  localparam logic [VW-1:0] VLast = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] VAct  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VsS   = VW'(VS_START);
  localparam logic [VW-1:0] VsE   = VW'(VS_END);

  typedef enum logic [1:0] {StIdle, StAccess, StAck} bus_state_e;

  bus_state_e    r_state, w_state_next;
  logic [15:0]   r_mem [0:(1 << AW) - 1];
  logic [15:0]   r_a_rdata, r_b_rdata, r_ctl_rdata, r_shift;
  logic          r_rd_ctl;
  logic          r_en, r_ie, r_vbp, r_irq;
  logic [HW-1:0] r_h;
  logic [VW-1:0] r_v;
  logic [AW-1:0] r_fetch_addr;
  logic          r_load_d1;
  logic          r_blank_d1, r_blank_d2, r_hs_d1, r_hs_d2, r_vs_d1, r_vs_d2;

  logic          w_acc, w_vram_sel, w_ctl_wr, w_vbp_set;
  logic          w_active, w_fetch, w_frame0;
  logic [AW-1:0] w_a_addr, w_b_addr;
  logic          w_unused_addr;

  assign w_unused_addr = ^{i_addr[22:AW+1], i_addr[0]};

  // Bus FSM
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= StIdle;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    o_wait_n     = 1'b1;
    case (r_state)
      StIdle: begin
        if (!i_reset && !i_go_n && (i_decode || i_decode_ctl)) begin
          w_state_next = StAccess;
          o_wait_n     = 1'b0;
        end
      end
      StAccess: begin
        w_state_next = StAck;
        o_wait_n     = 1'b0;
      end
      StAck: begin
        if (i_go_n) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  assign w_acc      = (r_state == StAccess);
  // Control space takes priority when both decodes are asserted.
  assign w_vram_sel = w_acc && i_decode && !i_decode_ctl;
  assign w_ctl_wr   = w_acc && i_decode_ctl && !i_addr[1] && !i_wel_n;
  assign w_a_addr   = i_addr[AW:1];

  // VRAM port A (bus) and port B (scan-out); port B sees old data on a same-word write.
  always_ff @(posedge i_clk) begin
    if (w_vram_sel && !i_wel_n) r_mem[w_a_addr][7:0]  <= i_datai[7:0];
    if (w_vram_sel && !i_weu_n) r_mem[w_a_addr][15:8] <= i_datai[15:8];
    if (w_acc) r_a_rdata <= r_mem[w_a_addr];
  end

  always_ff @(posedge i_clk) begin
    if (w_fetch) r_b_rdata <= r_mem[w_b_addr];
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rd_ctl    <= 1'b0;
      r_ctl_rdata <= 16'h0000;
    end else if (w_acc) begin
      r_rd_ctl    <= i_decode_ctl;
      r_ctl_rdata <= i_addr[1] ? 16'h0000 : {13'b0, r_vbp, r_ie, r_en};
    end
  end

  assign o_datao = (r_state == StAck) ? (r_rd_ctl ? r_ctl_rdata : r_a_rdata) : 16'h0000;

  // Control/status register
  assign w_vbp_set = (r_v == VAct) && (r_h == '0);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_en  <= 1'b0;
      r_ie  <= 1'b0;
      r_vbp <= 1'b0;
      r_irq <= 1'b0;
    end else begin
      if (w_ctl_wr) begin
        r_en <= i_datai[0];
        r_ie <= i_datai[1];
      end
      if (w_vbp_set)                  r_vbp <= 1'b1;
      else if (w_ctl_wr && i_datai[2]) r_vbp <= 1'b0;
      r_irq <= r_vbp & r_ie;
    end
  end

  assign o_irq = r_irq;

  // Raster counters
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_h <= '0;
      r_v <= '0;
    end else if (r_h == HLast) begin
      r_h <= '0;
      r_v <= (r_v == VLast) ? '0 : r_v + 1'b1;
    end else begin
      r_h <= r_h + 1'b1;
    end
  end

  assign w_active = (r_h < HAct) && (r_v < VAct);
  assign w_fetch  = w_active && (r_h[3:0] == 4'd0);
  assign w_frame0 = (r_h == '0) && (r_v == '0);
  assign w_b_addr = w_frame0 ? '0 : r_fetch_addr;

  always_ff @(posedge i_clk) begin
    if (i_reset)      r_fetch_addr <= '0;
    else if (w_fetch) r_fetch_addr <= w_b_addr + 1'b1;
  end

  // Stage 1: RAM read; stage 2: shift-register load. Sync/blank ride alongside.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_load_d1  <= 1'b0;
      r_shift    <= 16'h0000;
      r_blank_d1 <= 1'b1;
      r_blank_d2 <= 1'b1;
      r_hs_d1    <= 1'b0;
      r_hs_d2    <= 1'b0;
      r_vs_d1    <= 1'b0;
      r_vs_d2    <= 1'b0;
    end else begin
      r_load_d1  <= w_fetch;
      r_shift    <= r_load_d1 ? r_b_rdata : {r_shift[14:0], 1'b0};
      r_blank_d1 <= !w_active;
      r_blank_d2 <= r_blank_d1;
      r_hs_d1    <= (r_h >= HsS) && (r_h < HsE);
      r_hs_d2    <= r_hs_d1;
      r_vs_d1    <= (r_v >= VsS) && (r_v < VsE);
      r_vs_d2    <= r_vs_d1;
    end
  end

  assign o_pixel = r_shift[15] & ~r_blank_d2 & r_en;
  assign o_hsync = r_hs_d2;
  assign o_vsync = r_vs_d2;
  assign o_blank = r_blank_d2;

endmodule

// File: tb/tb_sun_video_fb.sv
// Directed bench for sun_video_fb with a 40x6 raster, 32x4 visible, 16-word VRAM.
module tb_sun_video_fb;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [22:0] addr = '0;
  logic        decode = 1'b0, decode_ctl = 1'b0;
  logic        wel_n = 1'b1, weu_n = 1'b1, go_n = 1'b1;
  logic [15:0] datai = '0;
  logic        wait_n;
  logic [15:0] datao;
  logic        pixel, hsync, vsync, blank, irq;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] rd, mid;
  int          nw;
  logic        ew;

  always #5 clk = ~clk;

  sun_video_fb #(
    .H_ACTIVE(32), .H_TOTAL(40), .HS_START(34), .HS_END(36),
    .V_ACTIVE(4), .V_TOTAL(6), .VS_START(4), .VS_END(5), .AW(4)
  ) dut (
    .i_clk(clk), .i_reset(reset), .i_addr(addr), .i_decode(decode),
    .i_decode_ctl(decode_ctl), .i_wel_n(wel_n), .i_weu_n(weu_n), .i_go_n(go_n),
    .o_wait_n(wait_n), .i_datai(datai), .o_datao(datao), .o_pixel(pixel),
    .o_hsync(hsync), .o_vsync(vsync), .o_blank(blank), .o_irq(irq)
  );

  // One bus cycle; inputs change 4 time units before the rising edge.
  task automatic bus_access(input logic ctl, input logic vram, input logic [22:0] a,
                            input logic wl, input logic wu, input logic [15:0] d);
    @(negedge clk);
    #1;
    addr = a; decode = vram; decode_ctl = ctl; wel_n = wl; weu_n = wu; datai = d; go_n = 1'b0;
    #1 ew = wait_n;
    nw = 0;
    @(negedge clk);
    mid = datao;
    if (!wait_n) nw++;
    @(negedge clk);
    rd = datao;
    if (!wait_n) nw++;
    #1;
    go_n = 1'b1; decode = 1'b0; decode_ctl = 1'b0; wel_n = 1'b1; weu_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (!wait_n) nw++;
    end
  endtask

  task automatic wait_sig(input int sel, input logic lvl, output int cyc, output bit ok);
    cyc = 0;
    ok  = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      cyc++;
      if (((sel == 0) ? hsync : vsync) === lvl) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (wait_n !== 1'b1) begin n_bad++; $display("FAIL rst_wait_n got %b want 1", wait_n); end
    n_cmp++; if (datao !== 16'h0) begin n_bad++; $display("FAIL rst_datao got %h want 0000", datao); end
    n_cmp++; if (pixel !== 1'b0) begin n_bad++; $display("FAIL rst_pixel got %b want 0", pixel); end
    n_cmp++; if (hsync !== 1'b0) begin n_bad++; $display("FAIL rst_hsync got %b want 0", hsync); end
    n_cmp++; if (vsync !== 1'b0) begin n_bad++; $display("FAIL rst_vsync got %b want 0", vsync); end
    n_cmp++; if (blank !== 1'b1) begin n_bad++; $display("FAIL rst_blank got %b want 1", blank); end
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL rst_irq got %b want 0", irq); end
    #1 reset = 1'b0;
  endtask

  task automatic test_ctl_reg;
    bus_access(1'b1, 1'b0, 23'd0, 1'b0, 1'b0, 16'h0003);
    bus_access(1'b1, 1'b0, 23'd0, 1'b1, 1'b1, 16'h0000);
    n_cmp++; if (rd !== 16'h0003) begin n_bad++; $display("FAIL ctl_rd_en_ie got %h want 0003", rd); end
    n_cmp++; if (nw !== 1) begin n_bad++; $display("FAIL ctl_wait_cycles got %0d want 1", nw); end
    bus_access(1'b1, 1'b0, 23'd2, 1'b1, 1'b1, 16'h0000);
    n_cmp++; if (rd !== 16'h0000) begin n_bad++; $display("FAIL ctl_rd_alias got %h want 0000", rd); end
    bus_access(1'b1, 1'b0, 23'd0, 1'b1, 1'b0, 16'h0000);
    bus_access(1'b1, 1'b0, 23'd0, 1'b1, 1'b1, 16'h0000);
    n_cmp++; if (rd !== 16'h0003) begin n_bad++; $display("FAIL ctl_upper_lane got %h want 0003", rd); end
    bus_access(1'b1, 1'b0, 23'd0, 1'b0, 1'b0, 16'h0000);
    bus_access(1'b1, 1'b0, 23'd0, 1'b1, 1'b1, 16'h0000);
    n_cmp++; if (rd !== 16'h0000) begin n_bad++; $display("FAIL ctl_clear got %h want 0000", rd); end
  endtask

  task automatic test_bus_rw;
    for (int w = 0; w < 16; w++) bus_access(1'b0, 1'b1, 23'(w * 2), 1'b0, 1'b0, 16'h0000);
    bus_access(1'b0, 1'b1, 23'd4, 1'b0, 1'b1, 16'hA5C3);
    n_cmp++; if (nw !== 1) begin n_bad++; $display("FAIL wr_wait_cycles got %0d want 1", nw); end
    n_cmp++; if (ew !== 1'b0) begin n_bad++; $display("FAIL wr_wait_early got %b want 0", ew); end
    bus_access(1'b0, 1'b1, 23'd4, 1'b1, 1'b1, 16'h0000);
    n_cmp++; if (rd !== 16'h00C3) begin n_bad++; $display("FAIL rd_low_lane got %h want 00c3", rd); end
    n_cmp++; if (mid !== 16'h0000) begin n_bad++; $display("FAIL datao_in_access got %h want 0000", mid); end
    n_cmp++; if (nw !== 1) begin n_bad++; $display("FAIL rd_wait_cycles got %0d want 1", nw); end
    bus_access(1'b0, 1'b1, 23'd6, 1'b1, 1'b0, 16'h1234);
    bus_access(1'b0, 1'b1, 23'd6, 1'b1, 1'b1, 16'h0000);
    n_cmp++; if (rd !== 16'h1200) begin n_bad++; $display("FAIL rd_high_lane got %h want 1200", rd); end
    bus_access(1'b1, 1'b1, 23'd10, 1'b0, 1'b0, 16'hBEEF);
    bus_access(1'b0, 1'b1, 23'd10, 1'b1, 1'b1, 16'h0000);
    n_cmp++; if (rd !== 16'h0000) begin n_bad++; $display("FAIL both_decode_vram got %h want 0000", rd); end
  endtask

  task automatic test_pixels;
    int  cyc;
    bit  ok;
    logic exp_p, exp_b;
    for (int w = 0; w < 8; w++) bus_access(1'b0, 1'b1, 23'(w * 2), 1'b0, 1'b0, 16'h8001);
    bus_access(1'b1, 1'b0, 23'd0, 1'b0, 1'b0, 16'h0001);
    wait_sig(1, 1'b1, cyc, ok);
    wait_sig(1, 1'b0, cyc, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL pix_sync got timeout want vsync fall"); end
    repeat (39) @(negedge clk);
    for (int h = 0; h < 40; h++) begin
      @(negedge clk);
      exp_b = (h >= 32);
      exp_p = (h < 32) && ((h % 16 == 0) || (h % 16 == 15));
      n_cmp++;
      if (pixel !== exp_p) begin
        n_bad++; $display("FAIL pixel_h%0d got %b want %b", h, pixel, exp_p);
      end
      n_cmp++;
      if (blank !== exp_b) begin
        n_bad++; $display("FAIL blank_h%0d got %b want %b", h, blank, exp_b);
      end
    end
  endtask

  task automatic test_irq_vbp;
    int   cyc;
    bit   ok;
    logic prev;
    wait_sig(1, 1'b1, cyc, ok);
    wait_sig(1, 1'b0, cyc, ok);
    bus_access(1'b1, 1'b0, 23'd0, 1'b0, 1'b0, 16'h0006);
    prev = irq;
    ok   = 1'b0;
    for (int i = 0; i < 400; i++) begin
      prev = irq;
      @(negedge clk);
      if (vsync) begin ok = 1'b1; break; end
    end
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL irq_sync got timeout want vsync rise"); end
    n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL irq_at_vblank got %b want 1", irq); end
    n_cmp++; if (prev !== 1'b0) begin n_bad++; $display("FAIL irq_before got %b want 0", prev); end
    bus_access(1'b1, 1'b0, 23'd0, 1'b1, 1'b1, 16'h0000);
    n_cmp++; if (rd !== 16'h0006) begin n_bad++; $display("FAIL ctl_vbp_set got %h want 0006", rd); end
    bus_access(1'b1, 1'b0, 23'd0, 1'b0, 1'b0, 16'h0006);
    bus_access(1'b1, 1'b0, 23'd0, 1'b1, 1'b1, 16'h0000);
    n_cmp++; if (rd !== 16'h0002) begin n_bad++; $display("FAIL ctl_vbp_clr got %h want 0002", rd); end
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_cleared got %b want 0", irq); end
  endtask

  task automatic test_sync;
    int cyc, vlen, hlen;
    bit ok;
    wait_sig(1, 1'b0, cyc, ok);
    wait_sig(1, 1'b1, cyc, ok);
    wait_sig(1, 1'b0, vlen, ok);
    n_cmp++; if (vlen !== 40) begin n_bad++; $display("FAIL vsync_len got %0d want 40", vlen); end
    wait_sig(1, 1'b1, cyc, ok);
    n_cmp++; if (vlen + cyc !== 240) begin n_bad++; $display("FAIL frame_period got %0d want 240", vlen + cyc); end
    wait_sig(0, 1'b0, cyc, ok);
    wait_sig(0, 1'b1, cyc, ok);
    wait_sig(0, 1'b0, hlen, ok);
    n_cmp++; if (hlen !== 2) begin n_bad++; $display("FAIL hsync_len got %0d want 2", hlen); end
    wait_sig(0, 1'b1, cyc, ok);
    n_cmp++; if (hlen + cyc !== 40) begin n_bad++; $display("FAIL line_period got %0d want 40", hlen + cyc); end
  endtask

  task automatic test_en_off;
    int   npix, nhs, nvs, hs_first, vs_first;
    logic phs, pvs, b1, b2;
    for (int w = 0; w < 16; w++) bus_access(1'b0, 1'b1, 23'(w * 2), 1'b0, 1'b0, 16'hFFFF);
    bus_access(1'b1, 1'b0, 23'd0, 1'b0, 1'b0, 16'h0000);
    npix = 0; nhs = 0; nvs = 0;
    phs = hsync; pvs = vsync;
    for (int i = 0; i < 480; i++) begin
      @(negedge clk);
      if (pixel) npix++;
      if (hsync && !phs) nhs++;
      if (vsync && !pvs) nvs++;
      phs = hsync; pvs = vsync;
    end
    n_cmp++; if (npix !== 0) begin n_bad++; $display("FAIL en_off_pixels got %0d want 0", npix); end
    n_cmp++; if (nhs !== 12) begin n_bad++; $display("FAIL en_off_hsyncs got %0d want 12", nhs); end
    n_cmp++; if (nvs !== 2) begin n_bad++; $display("FAIL en_off_vsyncs got %0d want 2", nvs); end
    wait_sig(0, 1'b1, hs_first, b1);
    repeat (10) @(negedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    n_cmp++; if ({hsync, vsync, blank, pixel, wait_n, irq} !== 6'b001010)
      begin n_bad++; $display("FAIL midreset_out got %b want 001010", {hsync, vsync, blank, pixel, wait_n, irq}); end
    n_cmp++; if (datao !== 16'h0) begin n_bad++; $display("FAIL midreset_datao got %h want 0000", datao); end
    #1 reset = 1'b0;
    hs_first = -1; vs_first = -1; b1 = 1'b0; b2 = 1'b1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (i == 1) b1 = blank;
      if (i == 2) b2 = blank;
      if (hsync && hs_first < 0) hs_first = i;
      if (vsync && vs_first < 0) vs_first = i;
    end
    n_cmp++; if (b1 !== 1'b1) begin n_bad++; $display("FAIL postreset_blank1 got %b want 1", b1); end
    n_cmp++; if (b2 !== 1'b0) begin n_bad++; $display("FAIL postreset_blank2 got %b want 0", b2); end
    n_cmp++; if (hs_first !== 36) begin n_bad++; $display("FAIL postreset_hsync got %0d want 36", hs_first); end
    n_cmp++; if (vs_first !== 162) begin n_bad++; $display("FAIL postreset_vsync got %0d want 162", vs_first); end
  endtask

  task automatic test_reset_access;
    @(negedge clk);
    #1;
    addr = 23'd4; decode = 1'b1; wel_n = 1'b1; weu_n = 1'b1; go_n = 1'b0;
    @(negedge clk);
    n_cmp++; if (wait_n !== 1'b0) begin n_bad++; $display("FAIL abort_in_access got %b want 0", wait_n); end
    #1;
    reset = 1'b1; go_n = 1'b1; decode = 1'b0;
    @(negedge clk);
    n_cmp++; if (wait_n !== 1'b1) begin n_bad++; $display("FAIL abort_wait_n got %b want 1", wait_n); end
    n_cmp++; if (datao !== 16'h0) begin n_bad++; $display("FAIL abort_datao got %h want 0000", datao); end
    #1 reset = 1'b0;
    bus_access(1'b0, 1'b1, 23'd4, 1'b1, 1'b1, 16'h0000);
    n_cmp++; if (rd !== 16'hFFFF) begin n_bad++; $display("FAIL after_abort_rd got %h want ffff", rd); end
    n_cmp++; if (nw !== 1) begin n_bad++; $display("FAIL after_abort_wait got %0d want 1", nw); end
  endtask

  initial begin
    test_reset();
    test_ctl_reg();
    test_bus_rw();
    test_pixels();
    test_irq_vbp();
    test_sync();
    test_en_off();
    test_reset_access();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sun_video_fb.md
SUN_VIDEO_FB -- requirements
Module: sun_video_fb

Interface
REQ-001 Parameter H_ACTIVE, default 1152, visible pixels per line; SHALL be a multiple of 16.
REQ-002 Parameter H_TOTAL, default 1504, clocks per line including blanking.
REQ-003 Parameter HS_START / HS_END, default 1192 / 1304, hsync asserted for H count in [HS_START, HS_END).
REQ-004 Parameter V_ACTIVE, default 900, visible lines per frame.
REQ-005 Parameter V_TOTAL, default 937, lines per frame; VS_START / VS_END, default 901 / 905, vsync asserted for V count in [VS_START, VS_END).
REQ-006 Parameter AW, default 16, VRAM word-address width; VRAM depth is 2^AW 16-bit words, and H_ACTIVE*V_ACTIVE/16 SHALL NOT exceed 2^AW.
REQ-007 clk  in  1  single clock for bus, raster and pixel logic, one pixel per clk.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 addr  in  23  byte address; bits [AW:1] select the VRAM word, bit [1] selects the control register.
REQ-010 decode  in  1  VRAM space selected; decode_ctl  in  1  control space selected.
REQ-011 wel_n / weu_n  in  1 each  active-low byte write strobes, lower [7:0] / upper [15:8]; both high means read.
REQ-012 go_n  in  1  active-low bus cycle strobe.
REQ-013 wait_n  out  1  active-low wait; low while an access is pending.
REQ-014 datai  in  16  write data; datao  out  16  read data.
REQ-015 pixel, hsync, vsync, blank  out  1 each  video outputs; hsync and vsync are active-high.
REQ-016 irq  out  1  vertical-blank interrupt request, active-high level.

Function
REQ-017 VRAM SHALL be a true dual-port 2^AW x 16 array: port A for the bus, port B read-only for scan-out, each with 1-cycle registered read; simultaneous accesses to the same word SHALL return the old data on port B.
REQ-018 The bus FSM SHALL have states IDLE, ACCESS, ACK, with one transition per cycle as follows.
REQ-019 IDLE -> ACCESS when go_n=0 and (decode or decode_ctl); in the ACCESS cycle, writes are performed with per-byte enables and reads are issued.
REQ-020 ACCESS -> ACK unconditionally; ACK -> IDLE when go_n=1. A new access requires go_n to return high first.
REQ-021 wait_n SHALL be 0 in ACCESS, 1 in IDLE and ACK, and 0 in the same cycle go_n falls with a decode.
REQ-022 datao SHALL hold valid read data in ACK and SHALL be 16'h0000 in all other states.
REQ-023 If decode and decode_ctl are both set, decode_ctl SHALL win and VRAM SHALL NOT be written.
REQ-024 Control register fields: bit0 EN, video enable, reset 0; bit1 IE, interrupt enable, reset 0; bit2 VBP, vblank pending, reset 0, read-only via write.
REQ-025 A control write SHALL set EN and IE from datai[1:0] (lower lane only) and SHALL clear VBP if datai[2]=1; a control read SHALL return {13'b0, VBP, IE, EN}.
REQ-026 H counter: 0..H_TOTAL-1, wraps to 0. V counter: increments on the H wrap, range 0..V_TOTAL-1, wraps to 0.
REQ-027 The fetch address SHALL reset to 0 when H=0 and V=0; it SHALL increment by 1 after each port-B read, one read per 16 active pixels, issued when H[3:0]=0, H<H_ACTIVE and V<V_ACTIVE.
REQ-028 The fetched word SHALL load a 16-bit shift register; pixel SHALL be bit 15 first (MSB leftmost), shifting left each clk.
REQ-029 pixel, hsync, vsync and blank SHALL be delayed together by exactly 2 clk from the H/V count that generates them (fixed latency: RAM read + shift load).
REQ-030 blank=1 when H>=H_ACTIVE or V>=V_ACTIVE (delayed per REQ-029). pixel SHALL be 0 when blank=1 or EN=0.
REQ-031 VBP SHALL be set on the cycle V becomes V_ACTIVE at H=0. If set and cleared in the same cycle, set SHALL win.
REQ-032 irq = VBP & IE, registered one cycle.
REQ-033 Raster counters SHALL run regardless of EN.

Reset
REQ-034 Reset SHALL force the FSM to IDLE, wait_n=1, datao=0, H=V=0, fetch address=0, shift register=0, EN=IE=VBP=0, irq=0, and pixel=hsync=vsync=0 with blank=1 on the next cycle; VRAM contents are unaffected.
REQ-035 Reset asserted during ACCESS SHALL abort the access; a write in that cycle MAY complete, and the next access SHALL start from IDLE.

Verification (small params: H_ACTIVE=32, H_TOTAL=40, HS 34/36, V_ACTIVE=4, V_TOTAL=6, VS 4/5, AW=4)
REQ-036 Write 16'hA5C3 to word 2 with wel_n=0, weu_n=1, then read word 2 -> datao low byte C3, high byte unchanged (0 after a zero-fill); wait_n low exactly 1 cycle per access.
REQ-037 Fill words 0..7 with 16'h8001, set EN=1 -> line 0 pixel sequence 1,0x14,1 repeated, starting 2 clk after H=0; blank=1 for H 32..39.
REQ-038 Set IE=1 and run to V=4, H=0 -> VBP=1, irq=1 one cycle later; control write datai=16'h0004 -> VBP=0, irq=0.
REQ-039 hsync high for exactly 2 clk per line, at H 34..35 plus 2 delay; vsync high for exactly 1 line (V=4); frame period is 240 clk.
REQ-040 With EN=0 and VRAM filled with 16'hFFFF -> pixel stays 0 while hsync and vsync keep toggling; assert reset mid-line -> H=V=0 and outputs match REQ-034.
